// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end.
//   Holds the PC, issues single-outstanding requests to instruction memory and
//   delivers fetched words to decode through a registered IF/ID slot
//   (valid/ready) backed by a one-entry skid buffer. Redirects flush everything
//   in flight and restart fetch at the (word-aligned) target.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pc_out / pc_plus4                current PC to external adder, sum back
//   redirect, redirect_pc, align_err branch/jump redirect, misalignment pulse
//   imem_req/addr/gnt/rvalid/rdata   instruction memory request/response
//   if_valid/instr/pc/pc4, id_ready  IF/ID slot handshake to decode
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        align_err,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready
);

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } slot_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] req_pc4_q, req_pc4_d;
    logic            drop_q, drop_d;
    logic            skid_valid_q, skid_valid_d;
    slot_t           skid_q, skid_d;
    logic            slot_valid_q, slot_valid_d;
    slot_t           slot_q, slot_d;
    logic            align_err_q, align_err_d;

    logic            slot_free;
    logic            gnt;

    // Slot can take a new word if empty or being consumed this cycle.
    assign slot_free = !slot_valid_q || id_ready;
    // Request depends on this cycle's id_ready so fetch can overlap consumption.
    assign imem_req  = !rst && (state_q == S_REQ) && !skid_valid_q && slot_free;
    assign gnt       = imem_req && imem_gnt;

    // Next-state and datapath update; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_pc4_d    = req_pc4_q;
        drop_d       = drop_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        slot_valid_d = slot_valid_q;
        slot_d       = slot_q;
        align_err_d  = 1'b0;

        // Consumed slot empties unless refilled below.
        if (slot_valid_q && id_ready) begin
            slot_valid_d = 1'b0;
        end

        if (redirect) begin
            pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
            slot_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            align_err_d  = |redirect_pc[1:0];
            case (state_q)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_REQ: begin
                    // A grant this cycle is for the old PC; its response must be eaten.
                    if (gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (gnt) begin
                        req_pc_d  = pc_q;
                        req_pc4_d = pc_plus4;
                        pc_d      = pc_plus4;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (slot_free) begin
                            slot_valid_d = 1'b1;
                            slot_d       = '{instr: imem_rdata, pc: req_pc_q, pc4: req_pc4_q};
                            state_d      = S_REQ;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_d       = '{instr: imem_rdata, pc: req_pc_q, pc4: req_pc4_q};
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        slot_valid_d = 1'b1;
                        slot_d       = skid_q;
                        skid_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            req_pc4_q    <= '0;
            drop_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_pc4_q    <= req_pc4_d;
            drop_q       <= drop_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            slot_valid_q <= slot_valid_d;
            slot_q       <= slot_d;
            align_err_q  <= align_err_d;
        end
    end

    assign pc_out    = pc_q;
    assign imem_addr = pc_q;
    assign align_err = align_err_q;
    assign if_valid  = slot_valid_q;
    assign if_instr  = slot_q.instr;
    assign if_pc     = slot_q.pc;
    assign if_pc4    = slot_q.pc4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: memory model, PC+4 adder model and a scoreboard
// of expected IF/ID transfers, exercised by one task per scenario.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        align_err;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_ready;

    int total = 0;
    int bad   = 0;

    // Memory / scoreboard state
    int          rlat     = 1;
    bit          gnt_en   = 1'b1;
    int          pend_cnt = 0;
    logic [31:0] pend_data;
    logic [95:0] sb[$];
    logic [31:0] gnt_log[$];
    logic [31:0] xfer_pc[$];

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .redirect(redirect), .redirect_pc(redirect_pc), .align_err(align_err),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    // External PC+4 adder
    assign pc_plus4 = pc_out + 32'd4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8C01_0000 | {16'h0000, a[15:0]};
    endfunction

    function automatic logic [31:0] log_at(input int k);
        if (gnt_log.size() > k) return gnt_log[k];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock: drive memory, grant, update scoreboard, advance to next negedge.
    task automatic cycle();
        logic [95:0] exp;
        imem_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
            end
        end
        #1;
        imem_gnt = gnt_en && imem_req;
        #1;
        if (rst) begin
            pend_cnt = 0;
            sb.delete();
        end else begin
            if (redirect) begin
                sb.delete();
            end else if (if_valid && id_ready) begin
                total++;
                xfer_pc.push_back(if_pc);
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, none expected", if_pc, if_instr);
                end else begin
                    exp = sb.pop_front();
                    if ({if_instr, if_pc, if_pc4} !== exp) begin
                        bad++;
                        $display("FAIL sb_xfer: got instr=%h pc=%h pc4=%h want instr=%h pc=%h pc4=%h",
                                 if_instr, if_pc, if_pc4, exp[95:64], exp[63:32], exp[31:0]);
                    end
                end
            end
            if (imem_gnt) begin
                gnt_log.push_back(imem_addr);
                if (!redirect) sb.push_back({mem_word(imem_addr), imem_addr, imem_addr + 32'd4});
                pend_cnt  = rlat;
                pend_data = mem_word(imem_addr);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; id_ready = 1'b1; gnt_en = 1'b1; rlat = 1;
        cycle();
        cycle();
        rst = 1'b0;
        sb.delete();
        gnt_log.delete();
        xfer_pc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req0: got %b want 0", imem_req); end
        cycle();
        cycle();
        #1;
        total++;
        if (pc_out !== RESET_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", pc_out, RESET_PC); end
        total++;
        if ({if_valid, align_err, imem_req} !== 3'b000) begin
            bad++; $display("FAIL rst_flags: got %b want 000", {if_valid, align_err, imem_req});
        end
        total++;
        if ({if_instr, if_pc, if_pc4} !== 96'h0) begin
            bad++; $display("FAIL rst_slot: got %h %h %h want 0", if_instr, if_pc, if_pc4);
        end
        rst = 1'b0;
        sb.delete(); gnt_log.delete(); xfer_pc.delete();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                total++;
                if (if_valid !== (c == 2)) begin
                    bad++; $display("FAIL seq_valid_c%0d: got %b want %b", c, if_valid, (c == 2));
                end
            end
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (log_at(k) !== RESET_PC + 32'(4 * k)) begin
                bad++; $display("FAIL seq_addr%0d: got %h want %h", k, log_at(k), RESET_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 15; c++) begin
            id_ready = !(c >= 4 && c <= 8);
            #1;
            if (c >= 4 && c <= 8) begin
                total++;
                if ({if_valid, if_instr, if_pc, if_pc4} !== {1'b1, 32'h8C01_0004, 32'h0040_0004, 32'h0040_0008}) begin
                    bad++; $display("FAIL stall_hold_c%0d: got v=%b instr=%h pc=%h pc4=%h want v=1 instr=8c010004 pc=00400004 pc4=00400008",
                                    c, if_valid, if_instr, if_pc, if_pc4);
                end
                total++;
                if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_c%0d: got %b want 0", c, imem_req); end
            end
            cycle();
        end
        total++;
        if (xfer_pc.size() != 4) begin
            bad++; $display("FAIL stall_count: got %0d want 4", xfer_pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (xfer_pc[k] !== RESET_PC + 32'(4 * k)) begin
                    bad++; $display("FAIL stall_order%0d: got %h want %h", k, xfer_pc[k], RESET_PC + 32'(4 * k));
                end
            end
        end
        id_ready = 1'b1;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        rlat = 3;
        for (int c = 0; c < 11; c++) begin
            redirect    = (c == 1);
            redirect_pc = 32'h0040_0100;
            #1;
            if (c >= 2 && c <= 7) begin
                total++;
                if (if_valid !== 1'b0) begin bad++; $display("FAIL rdw_flush_c%0d: got %b want 0", c, if_valid); end
            end
            if (c == 2) begin
                total++;
                if (align_err !== 1'b0) begin bad++; $display("FAIL rdw_align: got %b want 0", align_err); end
            end
            if (c == 8) begin
                total++;
                if ({if_valid, if_pc} !== {1'b1, 32'h0040_0100}) begin
                    bad++; $display("FAIL rdw_first: got v=%b pc=%h want v=1 pc=00400100", if_valid, if_pc);
                end
            end
            cycle();
        end
        redirect = 1'b0;
        rlat = 1;
        total++;
        if (log_at(1) !== 32'h0040_0100) begin bad++; $display("FAIL rdw_addr: got %h want 00400100", log_at(1)); end
        total++;
        if (xfer_pc.size() == 0 || xfer_pc[0] !== 32'h0040_0100) begin
            bad++; $display("FAIL rdw_xfer: got %0d transfers want first pc 00400100", xfer_pc.size());
        end
    endtask

    task automatic test_redirect_gnt();
        bit leaked;
        leaked = 1'b0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            redirect    = (c == 4);
            redirect_pc = 32'h0040_0200;
            #1;
            if (if_valid && if_instr === mem_word(32'h0040_0008)) leaked = 1'b1;
            if (c >= 5 && c <= 7) begin
                total++;
                if (if_valid !== 1'b0) begin bad++; $display("FAIL rdg_flush_c%0d: got %b want 0", c, if_valid); end
            end
            if (c == 8) begin
                total++;
                if ({if_valid, if_pc, if_pc4} !== {1'b1, 32'h0040_0200, 32'h0040_0204}) begin
                    bad++; $display("FAIL rdg_first: got v=%b pc=%h pc4=%h want v=1 pc=00400200 pc4=00400204",
                                    if_valid, if_pc, if_pc4);
                end
            end
            cycle();
        end
        redirect = 1'b0;
        total++;
        if ({log_at(2), log_at(3)} !== {32'h0040_0008, 32'h0040_0200}) begin
            bad++; $display("FAIL rdg_addrs: got %h %h want 00400008 00400200", log_at(2), log_at(3));
        end
        total++;
        if (leaked !== 1'b0) begin bad++; $display("FAIL rdg_leak: got %b want 0", leaked); end
    endtask

    task automatic test_align();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            redirect    = (c == 0);
            redirect_pc = 32'h0040_0102;
            gnt_en      = (c != 0);
            #1;
            if (c == 1) begin
                total++;
                if ({align_err, pc_out} !== {1'b1, 32'h0040_0100}) begin
                    bad++; $display("FAIL aln_pulse: got err=%b pc=%h want err=1 pc=00400100", align_err, pc_out);
                end
            end
            if (c == 2) begin
                total++;
                if (align_err !== 1'b0) begin bad++; $display("FAIL aln_once: got %b want 0", align_err); end
            end
            cycle();
        end
        redirect = 1'b0;
        gnt_en   = 1'b1;
        total++;
        if (log_at(0) !== 32'h0040_0100) begin bad++; $display("FAIL aln_addr: got %h want 00400100", log_at(0)); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            redirect    = (c == 0);
            redirect_pc = 32'hFFFF_FFFC;
            gnt_en      = (c != 0);
            cycle();
        end
        redirect = 1'b0;
        gnt_en   = 1'b1;
        total++;
        if ({log_at(0), log_at(1)} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
            bad++; $display("FAIL wrap_addrs: got %h %h want fffffffc 00000000", log_at(0), log_at(1));
        end
    endtask

    task automatic test_reset_stalled();
        int idx;
        idx = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            id_ready = (c < 2) || (c >= 5);
            rst      = (c == 3) || (c == 4);
            #1;
            if (c == 3) begin
                total++;
                if (if_valid !== 1'b1) begin bad++; $display("FAIL rss_pre: got %b want 1", if_valid); end
            end
            if (c == 4) begin
                total++;
                if ({if_valid, imem_req, pc_out} !== {2'b00, RESET_PC}) begin
                    bad++; $display("FAIL rss_cleared: got v=%b req=%b pc=%h want v=0 req=0 pc=%h",
                                    if_valid, imem_req, pc_out, RESET_PC);
                end
            end
            if (c == 5) idx = gnt_log.size();
            cycle();
        end
        rst = 1'b0;
        id_ready = 1'b1;
        total++;
        if (log_at(idx) !== RESET_PC) begin bad++; $display("FAIL rss_restart: got %h want %h", log_at(idx), RESET_PC); end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; pend_data = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_align();
        test_wrap();
        test_reset_stalled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
